data_convert_fifo_gen: RTL and testbench
========================================

DATA_CONVERT_FIFO_GEN -- requirements
Module: data_convert_fifo_gen

Interface
REQ-001 Parameter WIDTH_IN, 128, input word width in bits.
REQ-002 Parameter RATIO, 8, input words packed per output word; power of two, 2..16.
REQ-003 Parameter WIDTH_OUT, 1152, output port width; SHALL be >= WIDTH_IN*RATIO.
REQ-004 Parameter DEPTH_LOG2, 7, log2 of packed-word storage depth (DEPTH = 2**DEPTH_LOG2).
REQ-005 Parameter ADDR_BITS, 10, threshold port width minus one.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 Next_Reg  in  1  synchronous soft clear, active-high.
REQ-009 din  in  WIDTH_IN  input word.
REQ-010 wr_en  in  1  write request.
REQ-011 rd_en  in  1  read request for one packed word.
REQ-012 dout  out  WIDTH_OUT  packed output word, registered.
REQ-013 M_count  in  ADDR_BITS+1  downstream threshold, in input-word units.
REQ-014 M_Ready  out  1  registered; occupancy >= M_count.
REQ-015 S_count  in  ADDR_BITS+1  upstream threshold, in packed-word units.
REQ-016 S_Ready  out  1  registered; room for more input.
REQ-017 empty  out  1  no complete packed word stored.
REQ-018 full  out  1  packed storage full.

Function
REQ-019 Write accepted iff wr_en && !full; din goes to lane pack_fill of a pack register; pack_fill increments mod RATIO.
REQ-020 On the accepted write that completes the pack (pack_fill==RATIO-1), the packed word SHALL be committed to storage the same edge; wide_count +1.
REQ-021 Read accepted iff rd_en && !empty; dout updates one cycle after the accepting edge and holds until the next accepted read.
REQ-022 wr_en while full, rd_en while empty: ignored; no state change.
REQ-023 Commit and accepted read on the same edge: wide_count unchanged, both pointers advance.
REQ-024 empty = (wide_count==0); full = (wide_count==DEPTH); both combinational from registered count.
REQ-025 Occupancy = wide_count*RATIO + pack_fill, width DEPTH_LOG2+log2(RATIO)+1, zero-extended to compare with M_count.
REQ-026 M_Ready next = (occupancy >= M_count), from post-edge state, one-cycle registered lag.
REQ-027 S_Ready next = (wide_count < S_count); S_count=0 holds S_Ready low.
REQ-028 dout bits above WIDTH_IN*RATIO SHALL be zero.
REQ-029 Pointers wrap mod DEPTH with no bubble.

Reset
REQ-030 rst: pointers, wide_count, pack_fill=0; dout=0; M_Ready=0; S_Ready=1; empty=1; full=0.
REQ-031 Next_Reg: same clear as rst except M_Ready/S_Ready, which re-evaluate next edge from cleared state; partial pack discarded.
REQ-032 rst/Next_Reg coincident with wr_en/rd_en: clear wins; request dropped.

Configuration
REQ-033 Macro DCF_LANE_SWAP_EN undefined: first written word of a pack occupies dout[WIDTH_IN-1:0], last occupies the top lane.
REQ-034 DCF_LANE_SWAP_EN defined: lane order reversed; first written word occupies lane RATIO-1, last occupies lane 0.

Verification (WIDTH_IN=128, RATIO=8, DEPTH_LOG2=4, WIDTH_OUT=1152)
REQ-035 After rst, write words 0..7 -> empty=0 one cycle after 8th write; rd_en -> next cycle dout[127:0]=0, dout[1023:896]=7, dout[1151:1024]=0 (reversed with DCF_LANE_SWAP_EN).
REQ-036 Write 128 words -> full=1, wide_count=16; 129th write ignored; read all 16 -> empty=1; further rd_en leaves dout unchanged.
REQ-037 M_count=12: after 11 writes M_Ready=0; 12th write -> M_Ready=1 on following cycle; read one word -> occupancy 4 -> M_Ready=0.
REQ-038 S_count=3: commit third packed word -> S_Ready=0 next cycle; one read -> S_Ready=1.
REQ-039 Storage 10 words, pack_fill=7: write + read same edge -> wide_count stays 10, pack_fill=0.
REQ-040 Write 5 words, pulse Next_Reg with wr_en=1 -> pack_fill=0, empty=1, dout=0; next 8 writes form a clean pack.

Source files
------------

// File: rtl/data_convert_fifo_gen.sv
// rtl/data_convert_fifo_gen.sv - packs RATIO input words into one wide word and buffers them in a FIFO.
// Optional DCF_LANE_SWAP_EN: first written word of a pack lands in the top lane instead of lane 0.
module data_convert_fifo_gen #(
  parameter int WIDTH_IN   = 128,
  parameter int RATIO      = 8,
  parameter int WIDTH_OUT  = 1152,
  parameter int DEPTH_LOG2 = 7,
  parameter int ADDR_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Next_Reg,
  input  logic [WIDTH_IN-1:0]  din,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic [WIDTH_OUT-1:0] dout,
  input  logic [ADDR_BITS:0]   M_count,
  output logic                 M_Ready,
  input  logic [ADDR_BITS:0]   S_count,
  output logic                 S_Ready,
  output logic                 empty,
  output logic                 full
);

  localparam int PACK_W = WIDTH_IN * RATIO;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int FILL_W = $clog2(RATIO);
  localparam int CNT_W  = DEPTH_LOG2 + 1;
  localparam int OCC_W  = DEPTH_LOG2 + FILL_W + 1;
  localparam int THR_W  = ADDR_BITS + 1;
  localparam int MCMP_W = (OCC_W > THR_W) ? OCC_W : THR_W;
  localparam int SCMP_W = (CNT_W > THR_W) ? CNT_W : THR_W;

  logic [PACK_W-1:0]     mem [DEPTH];
  logic [PACK_W-1:0]     pack_reg;
  logic [PACK_W-1:0]     pack_word;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]      wide_count;
  logic [CNT_W-1:0]      count_next;
  logic [FILL_W-1:0]     pack_fill;
  logic [FILL_W-1:0]     fill_next;
  logic [FILL_W-1:0]     lane;
  logic [OCC_W-1:0]      occ_next;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  commit;
  logic                  m_next;
  logic                  s_next;

  assign empty  = (wide_count == '0);
  assign full   = (wide_count == CNT_W'(DEPTH));
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;
  assign commit = wr_acc && (pack_fill == FILL_W'(RATIO - 1));

`ifdef DCF_LANE_SWAP_EN
  assign lane = FILL_W'(RATIO - 1) - pack_fill;
`else
  assign lane = pack_fill;
`endif

  // The completing word is merged combinationally so the pack commits on its own write edge.
  always_comb begin
    pack_word = pack_reg;
    pack_word[lane*WIDTH_IN +: WIDTH_IN] = din;
  end

  always_comb begin
    fill_next  = pack_fill;
    count_next = wide_count;
    if (Next_Reg) begin
      fill_next  = '0;
      count_next = '0;
    end else begin
      if (wr_acc) fill_next = pack_fill + FILL_W'(1);
      case ({commit, rd_acc})
        2'b10:   count_next = wide_count + CNT_W'(1);
        2'b01:   count_next = wide_count - CNT_W'(1);
        default: count_next = wide_count;
      endcase
    end
  end

  // Ready flags are judged on the state this edge will leave behind.
  assign occ_next = {count_next, {FILL_W{1'b0}}} + OCC_W'(fill_next);
  assign m_next   = MCMP_W'(occ_next) >= MCMP_W'(M_count);
  assign s_next   = SCMP_W'(count_next) < SCMP_W'(S_count);

  always_ff @(posedge clk) begin
    if (commit && !rst && !Next_Reg) mem[wr_ptr] <= pack_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wide_count <= '0;
      pack_fill  <= '0;
      pack_reg   <= '0;
      dout       <= '0;
      M_Ready    <= 1'b0;
      S_Ready    <= 1'b1;
    end else begin
      wide_count <= count_next;
      pack_fill  <= fill_next;
      M_Ready    <= m_next;
      S_Ready    <= s_next;
      if (Next_Reg) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        pack_reg <= '0;
        dout     <= '0;
      end else begin
        if (wr_acc) pack_reg <= pack_word;
        if (commit) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (rd_acc) begin
          dout   <= WIDTH_OUT'(mem[rd_ptr]);
          rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_data_convert_fifo_gen.sv
// tb/tb_data_convert_fifo_gen.sv - scoreboard bench for data_convert_fifo_gen with a queue-based reference model.
module tb_data_convert_fifo_gen;

  localparam int WI = 128;
  localparam int R  = 8;
  localparam int WO = 1152;
  localparam int DL = 4;
  localparam int AB = 10;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Next_Reg = 1'b0;
  logic [WI-1:0] din = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [WO-1:0] dout;
  logic [AB:0]   M_count = '0;
  logic          M_Ready;
  logic [AB:0]   S_count = 11'd4;
  logic          S_Ready;
  logic          empty;
  logic          full;

  data_convert_fifo_gen #(.WIDTH_IN(WI), .RATIO(R), .WIDTH_OUT(WO), .DEPTH_LOG2(DL), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .Next_Reg(Next_Reg), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .M_count(M_count), .M_Ready(M_Ready), .S_count(S_count), .S_Ready(S_Ready),
    .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [WI*R-1:0] store_q[$];
  logic [WI-1:0]   part_q[$];
  logic [WO-1:0]   exp_q[$];
  logic            exp_m = 1'b0;
  logic            exp_s = 1'b1;

  task automatic chk(input string name, input logic [WO-1:0] act, input logic [WO-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [WI*R-1:0] build_pack();
    logic [WI*R-1:0] w = '0;
    for (int i = 0; i < R; i++) begin
`ifdef DCF_LANE_SWAP_EN
      w[(R-1-i)*WI +: WI] = part_q[i];
`else
      w[i*WI +: WI] = part_q[i];
`endif
    end
    return w;
  endfunction

  // Reference model: acceptance decided from the model's pre-edge contents.
  task automatic model_edge(input logic w, input logic r, input logic nr, input logic [WI-1:0] d);
    bit m_full  = (store_q.size() == D);
    bit m_empty = (store_q.size() == 0);
    if (nr) begin
      store_q.delete();
      part_q.delete();
    end else begin
      if (r && !m_empty) exp_q.push_back(WO'(store_q.pop_front()));
      if (w && !m_full) begin
        part_q.push_back(d);
        if (part_q.size() == R) begin
          store_q.push_back(build_pack());
          part_q.delete();
        end
      end
    end
    exp_m = (store_q.size() * R + part_q.size()) >= int'(M_count);
    exp_s = store_q.size() < int'(S_count);
  endtask

  task automatic cyc(input logic w, input logic r, input logic nr, input logic [WI-1:0] d);
    wr_en = w; rd_en = r; Next_Reg = nr; din = d;
    @(posedge clk);
    model_edge(w, r, nr, d);
    @(negedge clk);
    chk("empty", WO'(empty), WO'(store_q.size() == 0));
    chk("full", WO'(full), WO'(store_q.size() == D));
    chk("M_Ready", WO'(M_Ready), WO'(exp_m));
    chk("S_Ready", WO'(S_Ready), WO'(exp_s));
    if (nr) chk("dout_clear", dout, '0);
    wr_en = 1'b0; rd_en = 1'b0; Next_Reg = 1'b0;
  endtask

  function automatic logic [WI-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) chk("dout_read", dout, exp_q.pop_front());
  end

  initial begin
    logic [WO-1:0] held;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", dout, '0);
    chk("rst_M_Ready", WO'(M_Ready), '0);
    chk("rst_S_Ready", WO'(S_Ready), WO'(1));
    chk("rst_empty", WO'(empty), WO'(1));
    chk("rst_full", WO'(full), '0);
    rst = 1'b0;
    exp_m = 1'b0; exp_s = 1'b1;

    // words 0..7 form one pack
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, WI'(i));
    cyc(1'b0, 1'b1, 1'b0, '0);
`ifdef DCF_LANE_SWAP_EN
    chk("lane_low", WO'(dout[127:0]), WO'(7));
    chk("lane_top", WO'(dout[1023:896]), '0);
`else
    chk("lane_low", WO'(dout[127:0]), '0);
    chk("lane_top", WO'(dout[1023:896]), WO'(7));
`endif
    chk("pad_zero", WO'(dout[1151:1024]), '0);

    // fill to full, overflow, drain, underflow
    cyc(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 129; i++) cyc(1'b1, 1'b0, 1'b0, rnd_word());
    chk("full_after_128", WO'(full), WO'(1));
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    chk("empty_after_drain", WO'(empty), WO'(1));
    held = dout;
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("dout_hold", dout, held);

    // M_count threshold
    M_count = 11'd12;
    cyc(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 1'b0, rnd_word());
    chk("m_ready_11", WO'(M_Ready), '0);
    cyc(1'b1, 1'b0, 1'b0, rnd_word());
    chk("m_ready_12", WO'(M_Ready), WO'(1));
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("m_ready_after_rd", WO'(M_Ready), '0);

    // S_count threshold
    S_count = 11'd3;
    cyc(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 24; i++) cyc(1'b1, 1'b0, 1'b0, rnd_word());
    chk("s_ready_3", WO'(S_Ready), '0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("s_ready_after_rd", WO'(S_Ready), WO'(1));

    // simultaneous commit and read with 10 stored words
    cyc(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 87; i++) cyc(1'b1, 1'b0, 1'b0, rnd_word());
    cyc(1'b1, 1'b1, 1'b0, rnd_word());
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    chk("ten_minus_nine", WO'(empty), '0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("ten_drained", WO'(empty), WO'(1));

    // soft clear discards partial pack
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, rnd_word());
    cyc(1'b1, 1'b0, 1'b1, rnd_word());
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, rnd_word());
    cyc(1'b0, 1'b1, 1'b0, '0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) begin
        M_count = 11'($urandom_range(0, 140));
        S_count = 11'($urandom_range(0, 17));
      end
      cyc(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 80) == 0, rnd_word());
    end

    // reset coincident with requests
    wr_en = 1'b1; rd_en = 1'b1; rst = 1'b1; din = rnd_word();
    @(posedge clk);
    store_q.delete(); part_q.delete();
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("rst_req_dout", dout, '0);
    chk("rst_req_empty", WO'(empty), WO'(1));
    chk("rst_req_M_Ready", WO'(M_Ready), '0);
    chk("rst_req_S_Ready", WO'(S_Ready), WO'(1));

    @(negedge clk);
    chk("scoreboard_drained", WO'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
